switch_allocator: RTL and testbench

- Separable input-first switch allocator. It sits downstream of the input ports and VC allocator, and upstream of the crossbar.
- Each cycle it picks at most one VC per input port, and at most one input port per output port. It then drives the input-port read selects and the crossbar input selects.
- Grants are gated by per-VC downstream on/off flow-control state.
- Fairness comes from round-robin pointers: one per input port over VCs, and one per output port over input ports.

---
 rtl/switch_allocator_pkg.sv | 8 +
 rtl/switch_allocator_if.sv | 17 +
 rtl/switch_allocator_arbiter.sv | 31 +++
 rtl/switch_allocator.sv | 59 +++++
 tb/tb_switch_allocator.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/switch_allocator_pkg.sv
// switch_allocator_pkg: router dimensions and port encoding shared by the allocator slice.
package switch_allocator_pkg;
  localparam int PORT_NUM = 5;
  localparam int VC_NUM = 2;
  localparam int VC_SIZE = $clog2(VC_NUM);
  localparam int PORT_SIZE = $clog2(PORT_NUM);
  typedef enum logic [PORT_SIZE-1:0] {LOCAL, NORTH, SOUTH, WEST, EAST} port_t;
endpackage

// File: rtl/switch_allocator_if.sv
// switch_allocator_if: request/flow-control inputs and grant/crossbar outputs of the switch allocator.
interface switch_allocator_if;
  import switch_allocator_pkg::*;
  logic [PORT_NUM-1:0][VC_NUM-1:0] request;
  port_t [PORT_NUM-1:0][VC_NUM-1:0] out_port;
  logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] downstream_vc;
  logic [PORT_NUM-1:0][VC_NUM-1:0] on_off;
  logic [PORT_NUM-1:0] valid_sel;
  logic [PORT_NUM-1:0][VC_SIZE-1:0] vc_sel;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] xbar_sel;
  logic [PORT_NUM-1:0] valid_flit;
  logic [PORT_NUM-1:0][VC_SIZE-1:0] out_vc;
  modport master (output request, out_port, downstream_vc, on_off,
                  input valid_sel, vc_sel, xbar_sel, valid_flit, out_vc);
  modport slave (input request, out_port, downstream_vc, on_off,
                 output valid_sel, vc_sel, xbar_sel, valid_flit, out_vc);
endinterface

// File: rtl/switch_allocator_arbiter.sv
// round_robin_arbiter: N-way round-robin arbiter; pointer moves past the winner only when update_en.
module round_robin_arbiter #(
  parameter int N = 2,
  localparam int W = N > 1 ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] request,
  input  logic         update_en,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx
);
  logic [W-1:0] ptr;
  logic [W-1:0] j;
  always_comb begin
    grant = '0;
    grant_idx = '0;
    j = '0;
    // scan from farthest to nearest so the closest requester to ptr is written last
    for (int i = N - 1; i >= 0; i--) begin
      j = W'((int'(ptr) + i) % N);
      if (request[j]) begin
        grant = N'(1) << j;
        grant_idx = j;
      end
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) ptr <= '0;
    else if (update_en) ptr <= W'((int'(grant_idx) + 1) % N);
endmodule

// File: rtl/switch_allocator.sv
// switch_allocator: separable input-first allocator, VC arbitration per input then input arbitration per output,
// gated by registered downstream on/off state; grants are combinational and forced low while rst is low.
module switch_allocator
  import switch_allocator_pkg::*;
(
  input logic clk,
  input logic rst,
  switch_allocator_if.slave bus
);
  logic [PORT_NUM-1:0][VC_NUM-1:0] on_off_q, eligible, g1;
  logic [PORT_NUM-1:0][VC_SIZE-1:0] cand;
  logic [PORT_NUM-1:0][PORT_NUM-1:0] s2_req, g2;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] win;
  logic [PORT_NUM-1:0] valid_sel, valid_flit;
  always_ff @(posedge clk or negedge rst)
    if (!rst) on_off_q <= '1;
    else on_off_q <= bus.on_off;
  always_comb begin
    eligible = '0;
    for (int p = 0; p < PORT_NUM; p++)
      for (int v = 0; v < VC_NUM; v++)
        eligible[p][v] = bus.request[p][v] & on_off_q[bus.out_port[p][v]][bus.downstream_vc[p][v]];
  end
  always_comb begin
    s2_req = '0;
    for (int p = 0; p < PORT_NUM; p++)
      s2_req[bus.out_port[p][cand[p]]][p] = |g1[p];
  end
  for (genvar i = 0; i < PORT_NUM; i++) begin : g_arb
    round_robin_arbiter #(.N(VC_NUM)) u_vc (
      .clk(clk), .rst(rst), .request(eligible[i]), .update_en(valid_sel[i]),
      .grant(g1[i]), .grant_idx(cand[i])
    );
    round_robin_arbiter #(.N(PORT_NUM)) u_in (
      .clk(clk), .rst(rst), .request(s2_req[i]), .update_en(valid_flit[i]),
      .grant(g2[i]), .grant_idx(win[i])
    );
  end
  always_comb begin
    valid_sel = '0;
    valid_flit = '0;
    bus.vc_sel = '0;
    bus.xbar_sel = '0;
    bus.out_vc = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      valid_sel |= g2[o];
      valid_flit[o] = rst & |s2_req[o];
    end
    valid_sel &= {PORT_NUM{rst}};
    for (int p = 0; p < PORT_NUM; p++)
      bus.vc_sel[p] = valid_sel[p] ? cand[p] : '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      bus.xbar_sel[o] = valid_flit[o] ? win[o] : '0;
      bus.out_vc[o] = valid_flit[o] ? bus.downstream_vc[win[o]][cand[win[o]]] : '0;
    end
    bus.valid_sel = valid_sel;
    bus.valid_flit = valid_flit;
  end
endmodule

// File: tb/tb_switch_allocator.sv
// tb_switch_allocator: directed checks of grants, fairness, flow control and reset for switch_allocator.
module tb_switch_allocator;
  import switch_allocator_pkg::*;
  logic clk = 0;
  logic rst;
  int checks = 0;
  int errors = 0;
  switch_allocator_if bus ();
  switch_allocator dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    bus.request = '0;
    for (int p = 0; p < PORT_NUM; p++)
      for (int v = 0; v < VC_NUM; v++) begin
        bus.out_port[p][v] = LOCAL;
        bus.downstream_vc[p][v] = '0;
      end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_valid_sel"}, 32'(bus.valid_sel), 0);
    chk({tag, "_valid_flit"}, 32'(bus.valid_flit), 0);
    chk({tag, "_vc_sel"}, 32'(bus.vc_sel), 0);
    chk({tag, "_xbar_sel"}, 32'(bus.xbar_sel), 0);
    chk({tag, "_out_vc"}, 32'(bus.out_vc), 0);
  endtask

  initial begin
    rst = 0;
    clear();
    bus.request = '1;
    bus.on_off = '1;
    #3;
    all_zero("reset_hold");
    next();
    rst = 1;
    // single request ip1 vc0 -> EAST, downstream vc 1
    clear();
    bus.request[1][0] = 1;
    bus.out_port[1][0] = EAST;
    bus.downstream_vc[1][0] = 1;
    #1;
    chk("single_valid_sel", 32'(bus.valid_sel), 32'b00010);
    chk("single_vc_sel1", 32'(bus.vc_sel[1]), 0);
    chk("single_valid_flit", 32'(bus.valid_flit), 32'b10000);
    chk("single_xbar_east", 32'(bus.xbar_sel[EAST]), 1);
    chk("single_out_vc_east", 32'(bus.out_vc[EAST]), 1);
    // three inputs contend for NORTH
    next();
    clear();
    for (int p = 0; p < 3; p++) begin
      bus.request[p][0] = 1;
      bus.out_port[p][0] = NORTH;
    end
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("contend_valid_sel", 32'(bus.valid_sel), 32'(1 << (k % 3)));
      chk("contend_xbar_north", 32'(bus.xbar_sel[NORTH]), 32'(k % 3));
      next();
    end
    // VC fairness at ip3
    clear();
    bus.request[3] = 2'b11;
    bus.out_port[3][0] = WEST;
    bus.out_port[3][1] = SOUTH;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("vcfair_valid_sel", 32'(bus.valid_sel), 32'b01000);
      chk("vcfair_vc_sel3", 32'(bus.vc_sel[3]), 32'(k % 2));
      chk("vcfair_valid_flit", 32'(bus.valid_flit), (k % 2) ? 32'b00100 : 32'b01000);
      next();
    end
    // flow control on EAST dvc1
    clear();
    bus.request[1][1] = 1;
    bus.out_port[1][1] = EAST;
    bus.downstream_vc[1][1] = 1;
    bus.on_off[EAST][1] = 0;
    #1;
    chk("fc_t_valid_sel", 32'(bus.valid_sel), 32'b00010);
    chk("fc_t_out_vc", 32'(bus.out_vc[EAST]), 1);
    next();
    bus.request[2][0] = 1;
    bus.out_port[2][0] = EAST;
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) bus.on_off[EAST][1] = 1;
      #1;
      chk("fc_blocked_valid_sel", 32'(bus.valid_sel), 32'b00100);
      chk("fc_blocked_xbar", 32'(bus.xbar_sel[EAST]), 2);
      chk("fc_blocked_out_vc", 32'(bus.out_vc[EAST]), 0);
      next();
    end
    #1;
    chk("fc_resume_valid_sel", 32'(bus.valid_sel), 32'b00010);
    chk("fc_resume_out_vc", 32'(bus.out_vc[EAST]), 1);
    next();
    // stage-2 loss: bring in_ptr[LOCAL] to 4 via ip3, then ip0 vs ip4
    clear();
    bus.request[3][0] = 1;
    #1;
    chk("s2_prep_valid_sel", 32'(bus.valid_sel), 32'b01000);
    next();
    clear();
    bus.request[0] = 2'b11;
    bus.downstream_vc[0][1] = 1;
    bus.request[4][0] = 1;
    #1;
    chk("s2_loss_valid_sel", 32'(bus.valid_sel), 32'b10000);
    chk("s2_loss_xbar_local", 32'(bus.xbar_sel[LOCAL]), 4);
    next();
    chk("s2_retry_valid_sel", 32'(bus.valid_sel), 32'b00001);
    chk("s2_retry_vc_sel0", 32'(bus.vc_sel[0]), 1);
    chk("s2_retry_out_vc", 32'(bus.out_vc[LOCAL]), 1);
    next();
    // mid-operation async reset during NORTH contention
    clear();
    for (int p = 0; p < 3; p++) begin
      bus.request[p][0] = 1;
      bus.out_port[p][0] = NORTH;
    end
    #1;
    chk("mid_pre0_valid_sel", 32'(bus.valid_sel), 32'b00001);
    next();
    chk("mid_pre1_valid_sel", 32'(bus.valid_sel), 32'b00010);
    #1;
    rst = 0;
    #1;
    all_zero("mid_reset");
    next();
    rst = 1;
    #1;
    chk("mid_after_valid_sel", 32'(bus.valid_sel), 32'b00001);
    chk("mid_after_xbar_north", 32'(bus.xbar_sel[NORTH]), 0);
    next();
    chk("mid_after2_valid_sel", 32'(bus.valid_sel), 32'b00010);
    clear();
    #1;
    all_zero("idle");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
